// File: rtl/harvard_pkg.sv
// Shared types and constants for the harvard top level and its data-memory arbiter.
package harvard_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam int PORT_CPU = 0;
    localparam int PORT_AUX = 1;

    localparam int unsigned DEF_AW = 8;
    localparam int unsigned DEF_DW = 8;

    // Index of the port that is not p.
    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/datamem_arbiter_rr_arb2.sv
// Two-way round-robin picker; the pointer register lives in the caller.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Tie goes to the port that was not served last.
    always_comb begin
        grant_valid = |req;
        case (req)
            2'b11:   grant_idx = ~last;
            2'b10:   grant_idx = 1'b1;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/datamem_arbiter.sv
// Round-robin arbiter sharing the single-ported datamem between CPU and aux port.
module datamem_arbiter
    import harvard_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          write0,
    input  logic          write1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_write,
    input  logic [DW-1:0] mem_dout
);

    arb_state_t    state;
    logic          cmd_port;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          last;
    logic [DW-1:0] rdata_q;
    logic [1:0]    ack_q;
    logic          mem_write_q;

    logic [1:0]    req_vec;
    logic          grant_valid;
    logic          grant_idx;
    logic          ld_idx;
    logic          ld_en;
    logic          ld_write;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;

    assign req_vec = {req1, req0};

    rr_arb2 u_rr_arb2 (
        .req         (req_vec),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Select which port's command gets latched: the arbiter's pick from IDLE,
    // or only the other port from DONE so the served port cannot cut in again.
    always_comb begin
        ld_idx = grant_idx;
        ld_en  = grant_valid;
        if (state == DONE) begin
            ld_idx = other_port(cmd_port);
            ld_en  = req_vec[ld_idx];
        end
        ld_write = ld_idx ? write1 : write0;
        ld_addr  = ld_idx ? addr1  : addr0;
        ld_wdata = ld_idx ? wdata1 : wdata0;
    end

    // Arbitration FSM with registered ack and write strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cmd_port    <= 1'b0;
            cmd_write   <= 1'b0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            last        <= 1'b1;
            rdata_q     <= '0;
            ack_q       <= 2'b00;
            mem_write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_q       <= 2'b00;
                    mem_write_q <= 1'b0;
                    if (ld_en) begin
                        cmd_port    <= ld_idx;
                        cmd_write   <= ld_write;
                        cmd_addr    <= ld_addr;
                        cmd_wdata   <= ld_wdata;
                        mem_write_q <= ld_write;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_write_q     <= 1'b0;
                    if (!cmd_write) begin
                        rdata_q <= mem_dout;
                    end
                    last            <= cmd_port;
                    ack_q           <= 2'b00;
                    ack_q[cmd_port] <= 1'b1;
                    state           <= DONE;
                end
                DONE: begin
                    ack_q       <= 2'b00;
                    mem_write_q <= 1'b0;
                    if (ld_en) begin
                        cmd_port    <= ld_idx;
                        cmd_write   <= ld_write;
                        cmd_addr    <= ld_addr;
                        cmd_wdata   <= ld_wdata;
                        mem_write_q <= ld_write;
                        state       <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    ack_q       <= 2'b00;
                    mem_write_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign ack0      = ack_q[PORT_CPU];
    assign ack1      = ack_q[PORT_AUX];
    assign mem_write = mem_write_q;
    assign mem_addr  = cmd_addr;
    assign mem_din   = cmd_wdata;
    assign rdata0    = rdata_q;
    assign rdata1    = rdata_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: transaction-level model plus directed scenarios.
module tb_datamem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, write0, write1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, mem_write;
    logic [7:0] rdata0, rdata1, mem_addr, mem_din, mem_dout;

    logic       pre_en;
    logic [7:0] pre_addr, pre_data;
    logic [7:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    datamem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .write0    (write0),
        .write1    (write1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_write (mem_write),
        .mem_dout  (mem_dout)
    );

    // datamem: synchronous write, combinational read, plus a preload path.
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (mem_write) mem[mem_addr] <= mem_din;
    end
    assign mem_dout = mem[mem_addr];

    // Transaction model: a granted access occupies one access cycle and one ack cycle.
    int         m_busy, m_phase, m_port, m_last, m_p;
    logic       m_take, m_wr;
    logic [7:0] m_addr, m_din, m_rdata;
    logic [7:0] shadow [256];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_phase = 0; m_port = 0; m_last = 1;
            m_wr = 1'b0; m_addr = 8'h00; m_din = 8'h00; m_rdata = 8'h00;
        end else begin
            m_take = 1'b0;
            m_p    = 0;
            if (pre_en) shadow[pre_addr] = pre_data;
            if (m_busy == 0) begin
                if (req0 || req1) begin
                    m_take = 1'b1;
                    m_p = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
                end
            end else if (m_phase == 0) begin
                if (m_wr) shadow[m_addr] = m_din;
                else m_rdata = shadow[m_addr];
                m_last  = m_port;
                m_phase = 1;
            end else begin
                m_p = 1 - m_port;
                if ((m_p == 0) ? req0 : req1) m_take = 1'b1;
                else m_busy = 0;
            end
            if (m_take) begin
                m_busy  = 1;
                m_phase = 0;
                m_port  = m_p;
                m_wr    = (m_p == 1) ? write1 : write0;
                m_addr  = (m_p == 1) ? addr1  : addr0;
                m_din   = (m_p == 1) ? wdata1 : wdata0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    logic       e_ack0, e_ack1, e_wr;
    always @(negedge clk) begin
        e_ack0 = (m_busy == 1) && (m_phase == 1) && (m_port == 0);
        e_ack1 = (m_busy == 1) && (m_phase == 1) && (m_port == 1);
        e_wr   = (m_busy == 1) && (m_phase == 0) && m_wr;
        n_checks++;
        if ({ack0, ack1, mem_write, mem_addr, mem_din, rdata0, rdata1} !==
            {e_ack0, e_ack1, e_wr, m_addr, m_din, m_rdata, m_rdata}) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t got ack=%b%b wr=%b addr=%h din=%h rd=%h/%h want ack=%b%b wr=%b addr=%h din=%h rd=%h",
                     $time, ack0, ack1, mem_write, mem_addr, mem_din, rdata0, rdata1,
                     e_ack0, e_ack1, e_wr, m_addr, m_din, m_rdata);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        step();
        pre_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Steps until the port's ack is seen; cyc = steps taken, -1 on timeout.
    task automatic wait_ack(input int port, input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if ((port == 0) ? ack0 : ack1) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ack port=%0d got=timeout want=ack within %0d", port, budget);
        end
    endtask

    int c, n0, n1, bad_order, bad_slot, prev;

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; write0 = 0; write1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        pre_en = 0; pre_addr = 0; pre_data = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_ack0", ack0, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rdata0", rdata0, 0);

        preload(8'h10, 8'hA5);
        preload(8'h30, 8'h5E);
        preload(8'h31, 8'hE1);
        preload(8'h01, 8'h42);
        preload(8'h02, 8'h00);
        preload(8'h40, 8'h11);

        // Single read
        req0 = 1; write0 = 0; addr0 = 8'h10;
        step();
        check("rd_access_ack0", ack0, 0);
        check("rd_access_wr", mem_write, 0);
        check("rd_access_addr", mem_addr, 8'h10);
        step();
        check("rd_ack0", ack0, 1);
        check("rd_rdata0", rdata0, 8'hA5);
        check("rd_rdata1", rdata1, 8'hA5);
        check("rd_wr", mem_write, 0);
        req0 = 0;
        step();
        check("rd_ack_pulse", ack0, 0);

        // Single write then read
        req1 = 1; write1 = 1; addr1 = 8'h20; wdata1 = 8'h3C;
        step();
        check("wr_strobe", mem_write, 1);
        check("wr_addr", mem_addr, 8'h20);
        check("wr_din", mem_din, 8'h3C);
        step();
        check("wr_ack1", ack1, 1);
        check("wr_strobe_1cyc", mem_write, 0);
        check("wr_rdata_held", rdata1, 8'hA5);
        req1 = 0;
        step();
        check("wr_mem", mem[8'h20], 8'h3C);
        req0 = 1; write0 = 0; addr0 = 8'h20;
        wait_ack(0, 6, c);
        check("wr_rd_latency", c, 2);
        check("wr_rd_rdata0", rdata0, 8'h3C);
        req0 = 0;
        step();

        // Simultaneous after reset
        do_reset();
        req0 = 1; write0 = 0; addr0 = 8'h01;
        req1 = 1; write1 = 1; addr1 = 8'h02; wdata1 = 8'h77;
        step();
        step();
        check("sim_ack0_first", ack0, 1);
        check("sim_ack1_not_yet", ack1, 0);
        check("sim_rdata0", rdata0, 8'h42);
        req0 = 0;
        step();
        check("sim_b2b_wr", mem_write, 1);
        check("sim_b2b_addr", mem_addr, 8'h02);
        step();
        check("sim_ack1", ack1, 1);
        req1 = 0;
        step();
        check("sim_mem", mem[8'h02], 8'h77);

        // Sustained contention
        do_reset();
        req0 = 1; write0 = 0; addr0 = 8'h30;
        req1 = 1; write1 = 0; addr1 = 8'h31;
        n0 = 0; n1 = 0; bad_order = 0; bad_slot = 0; prev = 1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (ack0 || ack1) begin
                if ((i % 2) != 0 || (ack0 && ack1)) bad_slot++;
                if (ack0) begin
                    n0++;
                    if (prev != 1) bad_order++;
                    prev = 0;
                    if (rdata0 !== 8'h5E) bad_order++;
                end
                if (ack1) begin
                    n1++;
                    if (prev != 0) bad_order++;
                    prev = 1;
                    if (rdata1 !== 8'hE1) bad_order++;
                end
            end else if ((i % 2) == 0) begin
                bad_slot++;
            end
        end
        check("cont_n0", n0, 5);
        check("cont_n1", n1, 5);
        check("cont_order", bad_order, 0);
        check("cont_slots", bad_slot, 0);
        req0 = 0; req1 = 0;
        step();
        step();

        // Reset during a write access
        req1 = 1; write1 = 1; addr1 = 8'h40; wdata1 = 8'h99;
        step();
        check("rstw_strobe", mem_write, 1);
        #2 rst = 1'b1;
        #1;
        check("rstw_wr_drop", mem_write, 0);
        check("rstw_ack0", ack0, 0);
        check("rstw_ack1", ack1, 0);
        check("rstw_addr", mem_addr, 0);
        req1 = 0;
        step();
        rst = 1'b0;
        step();
        check("rstw_mem_kept", mem[8'h40], 8'h11);
        req0 = 1; write0 = 0; addr0 = 8'h40;
        wait_ack(0, 6, c);
        check("rstw_idle_latency", c, 2);
        check("rstw_rdata0", rdata0, 8'h11);
        req0 = 0;
        step();
        step();

        // Hold-over: port 0 keeps req high with port 1 idle
        req0 = 1; write0 = 0; addr0 = 8'h10;
        wait_ack(0, 6, c);
        check("hold_first", c, 2);
        wait_ack(0, 8, c);
        check("hold_second", c, 3);
        check("hold_rdata0", rdata0, 8'hA5);
        req0 = 0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
